// File: rtl/gfx256_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one 256-bit wishbone write port among NREQ requesters.
// Latency : write pulse in cycle 0 -> m_write_o in cycle 2 when idle; req_ack_o one cycle after m_ack_i.
// Backpres: one buffered write per requester; a pulse while that buffer is full is dropped and flags ovf_o.
// Option  : define GFX256_WR_ARB_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module gfx256_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int RRW  = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_write_i,
  input  logic [NREQ*32-1:0]  req_addr_i,
  input  logic [NREQ*32-1:0]  req_sel_i,
  input  logic [NREQ*256-1:0] req_dat_i,
  output logic [NREQ-1:0]     req_ack_o,
  output logic                m_write_o,
  output logic [31:0]         m_addr_o,
  output logic [31:0]         m_sel_o,
  output logic [255:0]        m_dat_o,
  input  logic                m_ack_i,
  output logic                busy_o,
  output logic [NREQ-1:0]     ovf_o
);

  localparam logic [RRW-1:0] LAST = RRW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [NREQ-1:0] r_pending, r_ovf, r_ack;
  logic [31:0]     r_buf_addr [NREQ];
  logic [31:0]     r_buf_sel  [NREQ];
  logic [255:0]    r_buf_dat  [NREQ];
  logic [RRW-1:0]  r_rr_ptr, r_gnt;
  logic            r_m_write;
  logic [31:0]     r_m_addr, r_m_sel;
  logic [255:0]    r_m_dat;

  logic [RRW-1:0]  w_ptr, w_gnt, w_win;
  logic            w_win_vld, w_load, w_ack_take;
  logic [NREQ-1:0] w_ack_vec, w_accept, w_drop;
  logic [31:0]     w_sel_addr, w_sel_sel;
  logic [255:0]    w_sel_dat;

  // Pointers that can exceed NREQ-1 (non power-of-2 NREQ) are folded onto the last requester.
  assign w_ptr = (r_rr_ptr > LAST) ? LAST : r_rr_ptr;
  assign w_gnt = (r_gnt > LAST) ? LAST : r_gnt;

  // The master ack only counts while a write is actually outstanding.
  assign w_ack_take = (r_state == ST_WAIT_ACK) && m_ack_i;

  // Per-requester ack/accept/drop decode; a pulse coinciding with its own ack refills the buffer.
  always_comb begin
    w_ack_vec = '0;
    w_accept  = '0;
    w_drop    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_ack_vec[i] = w_ack_take && (w_gnt == RRW'(i));
      w_accept[i]  = req_write_i[i] && (!r_pending[i] || w_ack_vec[i]);
      w_drop[i]    = req_write_i[i] && r_pending[i] && !w_ack_vec[i];
    end
  end

  // Winner selection among pending requesters.
  always_comb begin
    int best;
    int d;
    w_win     = LAST;
    w_win_vld = 1'b0;
    best      = NREQ;
    d         = 0;
`ifdef GFX256_WR_ARB_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_win     = RRW'(i);
        w_win_vld = 1'b1;
      end
    end
`else
    // Distance from the slot after rr_ptr; the smallest distance wins.
    for (int i = 0; i < NREQ; i++) begin
      if (r_pending[i]) begin
        d = (i + 2 * NREQ - 1 - int'(w_ptr)) % NREQ;
        if (d < best) begin
          best      = d;
          w_win     = RRW'(i);
          w_win_vld = 1'b1;
        end
      end
    end
`endif
  end

  // Steer the winning buffer onto the master-side load path.
  always_comb begin
    w_sel_addr = r_buf_addr[0];
    w_sel_sel  = r_buf_sel[0];
    w_sel_dat  = r_buf_dat[0];
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == RRW'(i)) begin
        w_sel_addr = r_buf_addr[i];
        w_sel_sel  = r_buf_sel[i];
        w_sel_dat  = r_buf_dat[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; DONE inserts one idle cycle between master cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_load      = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: if (m_ack_i) w_state_nxt = ST_DONE;
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Control and master-side registers; reset discards pending writes and any in-flight cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_ovf     <= '0;
      r_ack     <= '0;
      r_rr_ptr  <= LAST;
      r_gnt     <= LAST;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_sel   <= '0;
      r_m_dat   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ack_vec) | w_accept;
      r_ovf     <= r_ovf | w_drop;
      r_ack     <= w_ack_vec;
      if (w_load) begin
        r_gnt     <= w_win;
        r_m_write <= 1'b1;
        r_m_addr  <= w_sel_addr;
        r_m_sel   <= w_sel_sel;
        r_m_dat   <= w_sel_dat;
      end
      if (w_ack_take) begin
        r_m_write <= 1'b0;
        r_rr_ptr  <= w_gnt;
      end
    end
  end

  // Write buffers carry data only; validity lives in r_pending, so they need no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREQ; i++) begin
      if (w_accept[i]) begin
        r_buf_addr[i] <= req_addr_i[32*i +: 32];
        r_buf_sel[i]  <= req_sel_i[32*i +: 32];
        r_buf_dat[i]  <= req_dat_i[256*i +: 256];
      end
    end
  end

  assign req_ack_o = r_ack;
  assign m_write_o = r_m_write;
  assign m_addr_o  = r_m_addr;
  assign m_sel_o   = r_m_sel;
  assign m_dat_o   = r_m_dat;
  assign ovf_o     = r_ovf;
  assign busy_o    = (|r_pending) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_gfx256_wr_arbiter.sv
// Bench for gfx256_wr_arbiter: directed writes, scoreboard of expected master cycles and acks.
// Round-robin expectations by default; fixed-priority expectations when GFX256_WR_ARB_PRIO_EN is defined.
module tb_gfx256_wr_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [2:0]   req_write_i;
  logic [95:0]  req_addr_i, req_sel_i;
  logic [767:0] req_dat_i;
  logic [2:0]   req_ack_o;
  logic         m_write_o;
  logic [31:0]  m_addr_o, m_sel_o;
  logic [255:0] m_dat_o;
  logic         m_ack_i;
  logic         busy_o;
  logic [2:0]   ovf_o;

  always #5 clk = ~clk;

  gfx256_wr_arbiter #(.NREQ(3), .RRW(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
    .req_ack_o(req_ack_o),
    .m_write_o(m_write_o), .m_addr_o(m_addr_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  typedef struct {
    logic [31:0]  a;
    logic [31:0]  s;
    logic [255:0] d;
  } mw_t;

  mw_t        exp_m[$];
  logic [2:0] exp_ack[$];
  mw_t        cur;
  logic       prev_mw = 1'b0;
  logic       auto_en = 1'b0;
  int         ack_dly = 0;
  int         wcnt    = 0;
  int         checks  = 0;
  int         errors  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] s, input logic [255:0] d);
    req_addr_i[32*i +: 32]  = a;
    req_sel_i[32*i +: 32]   = s;
    req_dat_i[256*i +: 256] = d;
    req_write_i[i]          = 1'b1;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] s, input logic [255:0] d,
                           input logic [2:0] ackv);
    exp_m.push_back('{a, s, d});
    exp_ack.push_back(ackv);
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    req_write_i = '0;
    m_ack_i     = 1'b0;
    auto_en     = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    auto_en = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      if (exp_m.size() == 0 && exp_ack.size() == 0 && !busy_o && !m_write_o) done = 1'b1;
    end
    chk(name, done, 1'b1);
    auto_en = 1'b0;
  endtask

  // Monitor: checks each new master cycle, its stability while held, and every ack pulse.
  always @(negedge clk) begin
    if (m_write_o && !prev_mw) begin
      if (exp_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h, expected no write", m_addr_o);
      end else begin
        cur = exp_m.pop_front();
        chk("m_addr", m_addr_o, cur.a);
        chk("m_sel", m_sel_o, cur.s);
        chk("m_dat", m_dat_o, cur.d);
      end
    end else if (m_write_o && prev_mw) begin
      chk("hold_addr", m_addr_o, cur.a);
      chk("hold_sel", m_sel_o, cur.s);
      chk("hold_dat", m_dat_o, cur.d);
    end
    if (req_ack_o != 3'b000) begin
      if (exp_ack.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %0b, expected none", req_ack_o);
      end else begin
        chk("req_ack", req_ack_o, exp_ack.pop_front());
      end
    end
    prev_mw = m_write_o;
  end

  // Master model: one-cycle ack, optionally automatic after ack_dly cycles of m_write_o.
  always @(posedge clk) begin
    #1;
    if (m_ack_i) begin
      m_ack_i = 1'b0;
      wcnt    = 0;
    end else if (!m_write_o) begin
      wcnt = 0;
    end else if (auto_en) begin
      if (wcnt >= ack_dly) m_ack_i = 1'b1;
      else wcnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int rep;
    int rmax;
    bit done;
    rst_i       = 1'b1;
    req_write_i = '0;
    req_addr_i  = '0;
    req_sel_i   = '0;
    req_dat_i   = '0;
    m_ack_i     = 1'b0;
    tick();
    do_reset();

    // Reset state
    chk("rst_m_write", m_write_o, 1'b0);
    chk("rst_req_ack", req_ack_o, 3'b000);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ovf", ovf_o, 3'b000);
    chk("rst_m_addr", m_addr_o, 32'h0);

    // Single write with cycle-exact latency
    set_req(0, 32'h100, 32'h0000000F, 256'hAB);
    expect_wr(32'h100, 32'h0000000F, 256'hAB, 3'b001);
    tick();                                   // cycle 1
    req_write_i = '0;
    chk("c1_m_write", m_write_o, 1'b0);
    chk("c1_busy", busy_o, 1'b1);
    tick();                                   // cycle 2
    chk("c2_m_write", m_write_o, 1'b1);
    tick(); tick(); tick();                   // cycle 5
    m_ack_i = 1'b1;
    tick();                                   // cycle 6
    chk("c6_req_ack", req_ack_o, 3'b001);
    chk("c6_m_write", m_write_o, 1'b0);
    tick();                                   // cycle 7
    chk("c7_busy", busy_o, 1'b0);
    chk("c7_req_ack", req_ack_o, 3'b000);

    // Simultaneous requests from reset: order 0,1,2 in both modes
    do_reset();
    set_req(0, 32'h10, 32'hFFFFFFFF, 256'h1111);
    set_req(1, 32'h20, 32'h0000FFFF, 256'h2222);
    set_req(2, 32'h30, 32'hFFFF0000, 256'h3333);
    expect_wr(32'h10, 32'hFFFFFFFF, 256'h1111, 3'b001);
    expect_wr(32'h20, 32'h0000FFFF, 256'h2222, 3'b010);
    expect_wr(32'h30, 32'hFFFF0000, 256'h3333, 3'b100);
    tick();
    req_write_i = '0;
    ack_dly = 1;
    drain("simul_drain");

    // Fairness: requester 0 re-pulses on its ack while 1 and 2 wait
    do_reset();
    set_req(0, 32'h10, 32'hFFFFFFFF, 256'h1111);
    set_req(1, 32'h20, 32'h0000FFFF, 256'h2222);
    set_req(2, 32'h30, 32'hFFFF0000, 256'h3333);
`ifdef GFX256_WR_ARB_PRIO_EN
    rmax = 2;
    expect_wr(32'h10, 32'hFFFFFFFF, 256'h1111, 3'b001);
    expect_wr(32'h14, 32'h000000F0, 256'h4000, 3'b001);
    expect_wr(32'h18, 32'h000000F0, 256'h4001, 3'b001);
    expect_wr(32'h20, 32'h0000FFFF, 256'h2222, 3'b010);
    expect_wr(32'h30, 32'hFFFF0000, 256'h3333, 3'b100);
`else
    rmax = 1;
    expect_wr(32'h10, 32'hFFFFFFFF, 256'h1111, 3'b001);
    expect_wr(32'h20, 32'h0000FFFF, 256'h2222, 3'b010);
    expect_wr(32'h30, 32'hFFFF0000, 256'h3333, 3'b100);
    expect_wr(32'h14, 32'h000000F0, 256'h4000, 3'b001);
`endif
    ack_dly = 1;
    auto_en = 1'b1;
    rep  = 0;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      req_write_i = '0;
      if (req_ack_o[0] && rep < rmax) begin
        set_req(0, 32'h14 + 32'(4 * rep), 32'h000000F0, 256'h4000 + 256'(rep));
        rep++;
      end else if (rep == rmax && exp_m.size() == 0 && exp_ack.size() == 0 && !busy_o) begin
        done = 1'b1;
      end
    end
    chk("fair_drain", done, 1'b1);
    chk("fair_ovf", ovf_o, 3'b000);
    auto_en = 1'b0;

    // Overflow: second pulse on requester 1 is dropped and flagged
    do_reset();
    set_req(1, 32'h40, 32'h0F0F0F0F, 256'hD1);
    expect_wr(32'h40, 32'h0F0F0F0F, 256'hD1, 3'b010);
    tick();                                   // cycle 1: pending[1] already set
    set_req(1, 32'h44, 32'hF0F0F0F0, 256'hD2);
    tick();                                   // cycle 2
    req_write_i = '0;
    tick();                                   // cycle 3
    chk("ovf_set", ovf_o, 3'b010);
    ack_dly = 0;
    drain("ovf_drain");
    chk("ovf_sticky", ovf_o, 3'b010);

    // Pulse coinciding with its own ack is accepted
    do_reset();
    set_req(2, 32'h50, 32'h00000001, 256'hE1);
    expect_wr(32'h50, 32'h00000001, 256'hE1, 3'b100);
    tick();                                   // cycle 1
    req_write_i = '0;
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    m_ack_i = 1'b1;
    set_req(2, 32'h54, 32'h00000002, 256'hE2);
    expect_wr(32'h54, 32'h00000002, 256'hE2, 3'b100);
    tick();                                   // cycle 4
    req_write_i = '0;
    drain("coinc_drain");
    chk("coinc_ovf", ovf_o, 3'b000);

    // Stall: ack withheld for 20 cycles
    do_reset();
    set_req(0, 32'h60, 32'hFFFF0000, 256'hCAFE_F00D);
    expect_wr(32'h60, 32'hFFFF0000, 256'hCAFE_F00D, 3'b001);
    tick();
    req_write_i = '0;
    tick();                                   // cycle 2
    for (int k = 0; k < 20; k++) begin
      chk("stall_m_write", m_write_o, 1'b1);
      chk("stall_addr", m_addr_o, 32'h60);
      chk("stall_sel", m_sel_o, 32'hFFFF0000);
      chk("stall_dat", m_dat_o, 256'hCAFE_F00D);
      chk("stall_no_ack", req_ack_o, 3'b000);
      tick();
    end
    m_ack_i = 1'b1;
    drain("stall_drain");

    // Reset while waiting for ack with two more pending
    do_reset();
    set_req(0, 32'h70, 32'h1, 256'h71);
    set_req(1, 32'h74, 32'h2, 256'h72);
    set_req(2, 32'h78, 32'h4, 256'h73);
    exp_m.push_back('{32'h70, 32'h1, 256'h71});
    tick();
    req_write_i = '0;
    tick();                                   // cycle 2
    tick();                                   // cycle 3: waiting for ack
    chk("mid_m_write", m_write_o, 1'b1);
    rst_i = 1'b1;
    tick();                                   // cycle 4
    rst_i = 1'b0;
    chk("mid_rst_m_write", m_write_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ovf", ovf_o, 3'b000);
    chk("mid_rst_ack", req_ack_o, 3'b000);
    m_ack_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("late_ack_none", req_ack_o, 3'b000);
      chk("late_m_write", m_write_o, 1'b0);
      chk("late_busy", busy_o, 1'b0);
    end

    chk("left_m", 32'(exp_m.size()), 32'd0);
    chk("left_ack", 32'(exp_ack.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
